seg_scan_driver: RTL and testbench
==================================

SEG_SCAN_DRIVER -- requirements
Module: seg_scan_driver

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 4, number of multiplexed digits (1..8).
REQ-002 SHALL have parameter REFRESH_DIV, default 100000, clock cycles per digit slot (>=2).
REQ-003 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port data_in  input  4*NUM_DIGITS  nibble per digit, digit 0 in bits [3:0].
REQ-006 SHALL have port load  input  1  capture strobe for data_in.
REQ-007 SHALL have port hex_mode  input  1  1 = show A-F for nibbles 10-15, 0 = blank them.
REQ-008 SHALL have port en  input  1  display enable.
REQ-009 SHALL have port seg  output  7  cathodes, active-low, bit 0 = segment a.
REQ-010 SHALL have port an  output  NUM_DIGITS  anodes, active-low, one-hot-low when lit.
REQ-011 SHALL have port dp  output  1  decimal point, active-low.

Function
REQ-012 SHALL use prescaler counting 0..REFRESH_DIV-1 and wrapping to 0; tick asserted in the cycle it equals REFRESH_DIV-1.
REQ-013 SHALL advance digit index 0..NUM_DIGITS-1 on each tick, wrapping NUM_DIGITS-1 -> 0.
REQ-014 SHALL hold a shadow register loaded from data_in on any cycle with load=1; display uses only the shadow.
REQ-015 SHALL register seg, an, dp; outputs reflect digit index and shadow value one cycle after they change.
REQ-016 SHALL decode 0-9 as 1000000,1111001,0100100,0110000,0011001,0010010,0000010,1111000,0000000,0010000 (bits 6..0).
REQ-017 SHALL decode 10-15 with hex_mode=1 as 0001000,0000011,1000110,0100001,0000110,0001110 (A,b,C,d,E,F); with hex_mode=0 as 1111111.
REQ-018 SHALL drive an low only at bit equal to digit index; when en=0 SHALL drive an all-ones, seg 1111111, dp 1, while prescaler and index keep running.
REQ-019 SHALL, when load and tick coincide, apply both: next digit shows newly loaded nibble.
REQ-020 SHALL sample hex_mode and en each cycle (not latched by load).

Reset
REQ-021 SHALL on rst=1 at clock edge set prescaler 0, digit index 0, shadow all zeros (plus dp shadow zeros), seg 1111111, an all-ones, dp 1.
REQ-022 SHALL let rst override load and tick in the same cycle; first lit output appears one cycle after rst deasserts (digit 0 showing 0 if en=1).

Configuration
REQ-023 SHALL honour macro SEG_SCAN_DP_EN: when defined, adds input dp_in (NUM_DIGITS bits, active-high), captured into shadow by load; dp = ~dp_in_shadow[index] when en=1.
REQ-024 SHALL, without SEG_SCAN_DP_EN, have no dp_in port and hold dp at 1 constantly, including after reset.

Structure
REQ-025 SHALL place the sixteen segment pattern constants and the blank pattern in shared package seg_pkg.
REQ-026 SHALL instantiate one combinational sub-module seg_decode (nibble, hex_mode -> 7-bit pattern) reused by future blocks.
REQ-027 SHALL size prescaler and index widths with $clog2 of REFRESH_DIV and NUM_DIGITS (min 1 bit).

Verification (NUM_DIGITS=4, REFRESH_DIV=4)
REQ-028 Reset: hold rst 3 cycles with load=1 -> seg 1111111, an 1111, dp 1; after release en=1 -> an 1110, seg 1000000.
REQ-029 Scan: load 16'h4321, en=1 -> an cycles 1110,1101,1011,0111 every 4 clocks with seg 1111001,0100100,0110000,0011001; wraps back to 1110.
REQ-030 Hex mode: load 16'hFEDA, hex_mode=1 -> digit 0 seg 0001000, digit 3 0001110; hex_mode=0 -> seg 1111111 on all four while an still scans.
REQ-031 Simultaneous load+tick: load 16'h0009 exactly on tick leaving digit 3 -> next digit 0 shows 0010000.
REQ-032 Enable: drop en mid-digit-2 -> an 1111 next cycle; raise en after 6 clocks -> an shows digit index per continued prescaler (digit 0 or 1), not restarted.
REQ-033 With SEG_SCAN_DP_EN: load dp_in 4'b0100 -> dp 0 only while an 1011; without macro dp stays 1 throughout.

Source files
------------

// File: rtl/seg_pkg.sv
// Shared seven-segment pattern constants (active-low, bit 0 = segment a).
package seg_pkg;

  localparam int unsigned SEG_W = 7;
  localparam int unsigned NIB_W = 4;

  typedef logic [SEG_W-1:0] seg_pat_t;

  localparam seg_pat_t SEG_BLANK = 7'b1111111;

  // Indexed by nibble value: 0-9 then A, b, C, d, E, F.
  localparam seg_pat_t SEG_PAT [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  function automatic logic is_hex_letter(input logic [NIB_W-1:0] nib);
    return nib > 4'd9;
  endfunction

endpackage

// File: rtl/seg_decode.sv
// Combinational nibble-to-segment decoder; letters A-F are blanked unless hex_mode_i.
module seg_decode
  import seg_pkg::*;
(
  input  logic [NIB_W-1:0] nibble_i,
  input  logic             hex_mode_i,
  output seg_pat_t         seg_o
);

  always_comb begin
    seg_o = SEG_PAT[nibble_i];
    if (is_hex_letter(nibble_i) && !hex_mode_i) begin
      seg_o = SEG_BLANK;
    end
  end

endmodule

// File: rtl/seg_scan_driver.sv
// Multiplexed seven-segment scan driver with registered active-low outputs.
// Define SEG_SCAN_DP_EN to add the per-digit decimal-point input dp_in.
module seg_scan_driver
  import seg_pkg::*;
#(
  parameter int unsigned NUM_DIGITS  = 4,
  parameter int unsigned REFRESH_DIV = 100000
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [4*NUM_DIGITS-1:0]     data_in,
  input  logic                        load,
  input  logic                        hex_mode,
  input  logic                        en,
`ifdef SEG_SCAN_DP_EN
  input  logic [NUM_DIGITS-1:0]       dp_in,
`endif
  output logic [6:0]                  seg,
  output logic [NUM_DIGITS-1:0]       an,
  output logic                        dp
);

  localparam int unsigned CNT_W  = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int unsigned IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int unsigned DATA_W = NIB_W * NUM_DIGITS;

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(NUM_DIGITS - 1);

  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [DATA_W-1:0]     shadow_q, shadow_d;
  seg_pat_t              seg_q, seg_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic                  dp_q, dp_d;
`ifdef SEG_SCAN_DP_EN
  logic [NUM_DIGITS-1:0] dp_sh_q, dp_sh_d;
  logic                  dp_sel_c;
`endif

  logic                  tick_c;
  logic [NIB_W-1:0]      nib_c;
  seg_pat_t              dec_c;

  assign tick_c = (cnt_q == CNT_MAX);

  // Prescaler, digit index and shadow capture; load and tick may both act in one cycle.
  always_comb begin
    cnt_d    = tick_c ? '0 : cnt_q + CNT_W'(1);
    idx_d    = idx_q;
    shadow_d = shadow_q;
    if (tick_c) begin
      idx_d = (idx_q == IDX_MAX) ? '0 : idx_q + IDX_W'(1);
    end
    if (load) begin
      shadow_d = data_in;
    end
`ifdef SEG_SCAN_DP_EN
    dp_sh_d = load ? dp_in : dp_sh_q;
`endif
  end

  // Select the nibble of the digit currently being scanned.
  always_comb begin
    nib_c = '0;
`ifdef SEG_SCAN_DP_EN
    dp_sel_c = 1'b0;
`endif
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx_q == IDX_W'(i)) begin
        nib_c = shadow_q[i*NIB_W +: NIB_W];
`ifdef SEG_SCAN_DP_EN
        dp_sel_c = dp_sh_q[i];
`endif
      end
    end
  end

  seg_decode u_decode (
    .nibble_i   (nib_c),
    .hex_mode_i (hex_mode),
    .seg_o      (dec_c)
  );

  // Output next-state: everything dark while disabled, scan keeps running underneath.
  always_comb begin
    seg_d = SEG_BLANK;
    an_d  = '1;
    dp_d  = 1'b1;
    if (en) begin
      seg_d = dec_c;
      for (int i = 0; i < NUM_DIGITS; i++) begin
        an_d[i] = (idx_q != IDX_W'(i));
      end
`ifdef SEG_SCAN_DP_EN
      dp_d = ~dp_sel_c;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q    <= '0;
      idx_q    <= '0;
      shadow_q <= '0;
      seg_q    <= SEG_BLANK;
      an_q     <= '1;
      dp_q     <= 1'b1;
`ifdef SEG_SCAN_DP_EN
      dp_sh_q  <= '0;
`endif
    end else begin
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      shadow_q <= shadow_d;
      seg_q    <= seg_d;
      an_q     <= an_d;
      dp_q     <= dp_d;
`ifdef SEG_SCAN_DP_EN
      dp_sh_q  <= dp_sh_d;
`endif
    end
  end

  assign seg = seg_q;
  assign an  = an_q;
  assign dp  = dp_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Scoreboard bench for seg_scan_driver (NUM_DIGITS=4, REFRESH_DIV=4).
module tb_seg_scan_driver;

  localparam int unsigned ND = 4;

  logic          clk;
  logic          rst;
  logic [4*ND-1:0] data_in;
  logic          load;
  logic          hex_mode;
  logic          en;
`ifdef SEG_SCAN_DP_EN
  logic [ND-1:0] dp_in;
`endif
  logic [6:0]    seg;
  logic [ND-1:0] an;
  logic          dp;

  int checks = 0;
  int errors = 0;

  logic [6:0]    q_seg [$];
  logic [ND-1:0] q_an  [$];
  logic          q_dp  [$];
  string         q_name[$];

  seg_scan_driver #(.NUM_DIGITS(ND), .REFRESH_DIV(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .data_in  (data_in),
    .load     (load),
    .hex_mode (hex_mode),
    .en       (en),
`ifdef SEG_SCAN_DP_EN
    .dp_in    (dp_in),
`endif
    .seg      (seg),
    .an       (an),
    .dp       (dp)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Monitor: compare every queued expectation against the outputs mid-cycle.
  always @(negedge clk) begin
    while (q_seg.size() != 0) begin
      logic [6:0]    es;
      logic [ND-1:0] ea;
      logic          ed;
      string         nm;
      es = q_seg.pop_front();
      ea = q_an.pop_front();
      ed = q_dp.pop_front();
      nm = q_name.pop_front();
      checks++;
      if (seg !== es || an !== ea || dp !== ed) begin
        errors++;
        $display("FAIL %s: got seg=%b an=%b dp=%b, want seg=%b an=%b dp=%b",
                 nm, seg, an, dp, es, ea, ed);
      end
    end
  end

  task automatic exp_out(input logic [6:0] s, input logic [ND-1:0] a,
                         input logic d, input string nm);
    q_seg.push_back(s);
    q_an.push_back(a);
    q_dp.push_back(d);
    q_name.push_back(nm);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Reset for three cycles with a pending load that must be ignored.
  task automatic do_reset();
    rst      = 1'b1;
    load     = 1'b1;
    data_in  = 16'hFFFF;
    hex_mode = 1'b0;
    en       = 1'b1;
`ifdef SEG_SCAN_DP_EN
    dp_in    = 4'b1111;
`endif
    step(3);
    exp_out(7'h7F, 4'b1111, 1'b1, "reset_state");
    rst  = 1'b0;
    load = 1'b0;
`ifdef SEG_SCAN_DP_EN
    dp_in = 4'b0000;
`endif
  endtask

  logic [6:0]    scan_seg [4];
  logic [ND-1:0] scan_an  [4];

  initial begin
    scan_seg = '{7'h79, 7'h24, 7'h30, 7'h19};
    scan_an  = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    rst = 1'b1; load = 1'b0; data_in = '0; hex_mode = 1'b0; en = 1'b1;
`ifdef SEG_SCAN_DP_EN
    dp_in = '0;
`endif

    // Reset and first lit output
    do_reset();
    step(1);
    exp_out(7'h40, 4'b1110, 1'b1, "release_digit0_zero");

    // Scan of 4321 with wrap-around
    do_reset();
    load = 1'b1; data_in = 16'h4321;
    step(1);
    load = 1'b0;
    exp_out(7'h40, 4'b1110, 1'b1, "scan_e0_old_shadow");
    step(3);
    exp_out(scan_seg[0], scan_an[0], 1'b1, "scan_d0_end");
    for (int d = 1; d <= 4; d++) begin
      step(1);
      exp_out(scan_seg[d % 4], scan_an[d % 4], 1'b1, $sformatf("scan_d%0d_start", d % 4));
      if (d < 4) begin
        step(3);
        exp_out(scan_seg[d], scan_an[d], 1'b1, $sformatf("scan_d%0d_end", d));
      end
    end

    // Hex mode on, then off mid-scan
    do_reset();
    hex_mode = 1'b1; load = 1'b1; data_in = 16'hFEDA;
    step(1);
    load = 1'b0;
    step(1);
    exp_out(7'h08, 4'b1110, 1'b1, "hex_A");
    step(3);
    exp_out(7'h21, 4'b1101, 1'b1, "hex_d");
    step(4);
    exp_out(7'h06, 4'b1011, 1'b1, "hex_E");
    step(4);
    exp_out(7'h0E, 4'b0111, 1'b1, "hex_F");
    hex_mode = 1'b0;
    step(2);
    exp_out(7'h7F, 4'b0111, 1'b1, "blank_F");
    step(2);
    exp_out(7'h7F, 4'b1110, 1'b1, "blank_A");
    step(4);
    exp_out(7'h7F, 4'b1101, 1'b1, "blank_d");

    // Load coinciding with the tick that leaves digit 3
    do_reset();
    step(15);
    load = 1'b1; data_in = 16'h0009;
    step(1);
    load = 1'b0;
    exp_out(7'h40, 4'b0111, 1'b1, "loadtick_d3_old");
    step(1);
    exp_out(7'h10, 4'b1110, 1'b1, "loadtick_d0_new");

    // Enable dropped mid-digit-2; scan continues underneath
    do_reset();
    load = 1'b1; data_in = 16'h4321;
    step(1);
    load = 1'b0;
    step(9);
    exp_out(7'h30, 4'b1011, 1'b1, "en_d2_lit");
    en = 1'b0;
    step(1);
    exp_out(7'h7F, 4'b1111, 1'b1, "en_off_first");
    step(5);
    exp_out(7'h7F, 4'b1111, 1'b1, "en_off_last");
    en = 1'b1;
    step(1);
    exp_out(7'h79, 4'b1110, 1'b1, "en_back_d0");
    step(4);
    exp_out(7'h24, 4'b1101, 1'b1, "en_back_d1");

`ifdef SEG_SCAN_DP_EN
    // Decimal point on digit 2 only
    do_reset();
    load = 1'b1; data_in = 16'h4321; dp_in = 4'b0100;
    step(1);
    load = 1'b0; dp_in = 4'b0000;
    step(3);
    exp_out(7'h79, 4'b1110, 1'b1, "dp_d0_off");
    step(1);
    exp_out(7'h24, 4'b1101, 1'b1, "dp_d1_off");
    step(4);
    exp_out(7'h30, 4'b1011, 1'b0, "dp_d2_on");
    step(3);
    exp_out(7'h30, 4'b1011, 1'b0, "dp_d2_on_end");
    step(1);
    exp_out(7'h19, 4'b0111, 1'b1, "dp_d3_off");
`endif

    repeat (2) @(posedge clk);
    checks++;
    if (q_seg.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d expectations left, want 0", q_seg.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
